// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings and adapter FSM states for the rggen
// register-access adapter.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_WRITE        = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_POSTED_WRITE = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } rggen_adapter_state;

endpackage

// File: rtl/rggen_adapter_watchdog.sv
// Access watchdog: counts wait cycles since the last issue and flags the
// wait cycle in which the TIMEOUT_CYCLES budget is used up.
module rggen_adapter_watchdog #(
    parameter int TIMEOUT_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int COUNTER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [COUNTER_WIDTH-1:0] counter;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counter <= '0;
        end else if (clear) begin
            counter <= '0;
        end else if (enable) begin
            counter <= counter + COUNTER_WIDTH'(1);
        end
    end

    // counter holds the completed wait cycles, so a match means this is the N-th one
    assign expire = enable && (counter == COUNTER_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rggen_adapter_core.sv
// Protocol-independent adapter between a bus front end and the register array:
// optional request slicer, registered response path and an access watchdog.
module rggen_adapter_core
    import rggen_rtl_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH       = 8,
    parameter int                         LOCAL_ADDRESS_WIDTH = 8,
    parameter int                         BUS_WIDTH           = 32,
    parameter int                         STROBE_WIDTH        = BUS_WIDTH / 8,
    parameter int                         REGISTERS           = 1,
    parameter bit                         PRE_DECODE          = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS        = '0,
    parameter int                         BYTE_SIZE           = 256,
    parameter bit                         ERROR_STATUS        = 1'b0,
    parameter logic [BUS_WIDTH-1:0]       DEFAULT_READ_DATA   = '0,
    parameter bit                         INSERT_SLICER       = 1'b0,
    parameter int                         TIMEOUT_CYCLES      = 0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  bus_valid,
    input  rggen_access                           bus_access,
    input  logic [ADDRESS_WIDTH-1:0]              bus_address,
    input  logic [BUS_WIDTH-1:0]                  bus_write_data,
    input  logic [STROBE_WIDTH-1:0]               bus_strobe,
    output logic                                  bus_ready,
    output rggen_status                           bus_status,
    output logic [BUS_WIDTH-1:0]                  bus_read_data,
    output logic                                  register_valid,
    output rggen_access                           register_access,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]        register_address,
    output logic [BUS_WIDTH-1:0]                  register_write_data,
    output logic [BUS_WIDTH-1:0]                  register_strobe,
    input  logic [REGISTERS-1:0]                  register_active,
    input  logic [REGISTERS-1:0]                  register_ready,
    input  logic [REGISTERS-1:0][1:0]             register_status,
    input  logic [REGISTERS-1:0][BUS_WIDTH-1:0]   register_read_data,
    output logic                                  o_busy,
    output logic                                  o_timeout
);

    localparam logic [ADDRESS_WIDTH:0] WINDOW_SIZE    = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);
    localparam bit                     BASE_ALIGNED   = (LOCAL_ADDRESS_WIDTH'(BASE_ADDRESS) == '0);
    localparam rggen_status            DEFAULT_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

    rggen_adapter_state                state;
    rggen_adapter_state                state_next;
    logic [ADDRESS_WIDTH:0]            offset;
    logic                              in_range;
    logic [LOCAL_ADDRESS_WIDTH-1:0]    local_address;
    logic [BUS_WIDTH-1:0]              expanded_strobe;
    logic                              issue;
    logic                              expire;
    logic                              done;
    logic [1:0]                        mux_status;
    logic [BUS_WIDTH-1:0]              mux_data;
    rggen_status                       capture_status;
    logic [BUS_WIDTH-1:0]              capture_data;
    logic                              capture_timeout;

    // An address below the base wraps into the extra top bit and fails the window test.
    assign offset        = {1'b0, bus_address} - {1'b0, BASE_ADDRESS};
    assign in_range      = !PRE_DECODE || (offset < WINDOW_SIZE);
    assign local_address = BASE_ALIGNED ? LOCAL_ADDRESS_WIDTH'(bus_address)
                                        : LOCAL_ADDRESS_WIDTH'(offset);

    if (STROBE_WIDTH == BUS_WIDTH) begin : g_bit_strobe
        assign expanded_strobe = bus_strobe;
    end else begin : g_byte_strobe
        always_comb begin
            expanded_strobe = '0;
            for (int i = 0; i < BUS_WIDTH; i++) begin
                expanded_strobe[i] = bus_strobe[i / 8];
            end
        end
    end

    if (INSERT_SLICER) begin : g_slicer
        rggen_access                    req_access;
        logic [LOCAL_ADDRESS_WIDTH-1:0] req_address;
        logic [BUS_WIDTH-1:0]           req_write_data;
        logic [BUS_WIDTH-1:0]           req_strobe;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                req_access     <= rggen_access'(2'b00);
                req_address    <= '0;
                req_write_data <= '0;
                req_strobe     <= '0;
            end else if (state == IDLE && bus_valid && in_range) begin
                req_access     <= bus_access;
                req_address    <= local_address;
                req_write_data <= bus_write_data;
                req_strobe     <= expanded_strobe;
            end
        end

        assign register_access     = req_access;
        assign register_address    = req_address;
        assign register_write_data = req_write_data;
        assign register_strobe     = req_strobe;
        assign issue               = (state == ISSUE);
    end else begin : g_direct
        assign register_access     = bus_access;
        assign register_address    = local_address;
        assign register_write_data = bus_write_data;
        assign register_strobe     = expanded_strobe;
        assign issue               = (state == IDLE) && bus_valid && in_range;
    end

    assign register_valid = issue;
    assign o_busy         = (state != IDLE);

    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
        rggen_adapter_watchdog #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_watchdog (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .clear   (issue),
            .enable  (state == WAIT),
            .expire  (expire)
        );
    end else begin : g_no_watchdog
        assign expire = 1'b0;
    end

    always_comb begin
        mux_status = '0;
        mux_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (register_active[i]) begin
                mux_status = mux_status | register_status[i];
                mux_data   = mux_data | register_read_data[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion priority: ready, then no register claiming the access, then watchdog.
    always_comb begin
        state_next      = state;
        capture_status  = DEFAULT_STATUS;
        capture_data    = DEFAULT_READ_DATA;
        capture_timeout = 1'b0;
        done            = 1'b0;
        if (issue || state == WAIT) begin
            if (|register_ready) begin
                capture_status = rggen_status'(mux_status);
                capture_data   = mux_data;
                done           = 1'b1;
            end else if (register_active == '0) begin
                done = 1'b1;
            end else if (expire) begin
                capture_status  = RGGEN_SLAVE_ERROR;
                capture_timeout = 1'b1;
                done            = 1'b1;
            end
        end
        case (state)
            IDLE: begin
                if (bus_valid) begin
                    if (!in_range) begin
                        state_next = RESPOND;
                    end else if (INSERT_SLICER) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = done ? RESPOND : WAIT;
                    end
                end
            end
            ISSUE, WAIT: state_next = done ? RESPOND : WAIT;
            RESPOND:     state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus_ready     <= 1'b0;
            bus_status    <= RGGEN_OKAY;
            bus_read_data <= '0;
            o_timeout     <= 1'b0;
        end else begin
            bus_ready <= (state_next == RESPOND);
            o_timeout <= (state_next == RESPOND) && capture_timeout;
            if (state_next == RESPOND) begin
                bus_status    <= capture_status;
                bus_read_data <= capture_data;
            end
        end
    end

endmodule

// File: tb/tb_rggen_adapter_core.sv
// Bench for rggen_adapter_core: a decoded, watchdog-equipped instance (A) and a
// sliced, undecoded instance (B), checked against a transaction-level model.
module tb_rggen_adapter_core;
    import rggen_rtl_pkg::*;

    localparam logic [31:0] A_DEFAULT = 32'hCAFE_0BAD;
    localparam logic [31:0] B_DEFAULT = 32'h5555_AAAA;
    localparam int          A_TIMEOUT = 4;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 i_clk = ~i_clk;

    logic              a_bus_valid;
    rggen_access       a_bus_access;
    logic [7:0]        a_bus_address;
    logic [31:0]       a_bus_write_data;
    logic [3:0]        a_bus_strobe;
    logic              a_bus_ready;
    rggen_status       a_bus_status;
    logic [31:0]       a_bus_read_data;
    logic              a_register_valid;
    rggen_access       a_register_access;
    logic [7:0]        a_register_address;
    logic [31:0]       a_register_write_data;
    logic [31:0]       a_register_strobe;
    logic [1:0]        a_reg_active;
    logic [1:0]        a_reg_ready;
    logic [1:0][1:0]   a_reg_status;
    logic [1:0][31:0]  a_reg_read_data;
    logic              a_busy;
    logic              a_timeout;

    logic              b_bus_valid;
    rggen_access       b_bus_access;
    logic [7:0]        b_bus_address;
    logic [31:0]       b_bus_write_data;
    logic [3:0]        b_bus_strobe;
    logic              b_bus_ready;
    rggen_status       b_bus_status;
    logic [31:0]       b_bus_read_data;
    logic              b_register_valid;
    rggen_access       b_register_access;
    logic [7:0]        b_register_address;
    logic [31:0]       b_register_write_data;
    logic [31:0]       b_register_strobe;
    logic [0:0]        b_reg_active;
    logic [0:0]        b_reg_ready;
    logic [0:0][1:0]   b_reg_status;
    logic [0:0][31:0]  b_reg_read_data;
    logic              b_busy;
    logic              b_timeout;

    rggen_adapter_core #(
        .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4),
        .REGISTERS(2), .PRE_DECODE(1'b1), .BASE_ADDRESS(8'h40), .BYTE_SIZE(16),
        .ERROR_STATUS(1'b1), .DEFAULT_READ_DATA(A_DEFAULT), .INSERT_SLICER(1'b0),
        .TIMEOUT_CYCLES(A_TIMEOUT)
    ) dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .bus_valid(a_bus_valid), .bus_access(a_bus_access), .bus_address(a_bus_address),
        .bus_write_data(a_bus_write_data), .bus_strobe(a_bus_strobe),
        .bus_ready(a_bus_ready), .bus_status(a_bus_status), .bus_read_data(a_bus_read_data),
        .register_valid(a_register_valid), .register_access(a_register_access),
        .register_address(a_register_address), .register_write_data(a_register_write_data),
        .register_strobe(a_register_strobe), .register_active(a_reg_active),
        .register_ready(a_reg_ready), .register_status(a_reg_status),
        .register_read_data(a_reg_read_data), .o_busy(a_busy), .o_timeout(a_timeout)
    );

    rggen_adapter_core #(
        .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .STROBE_WIDTH(4),
        .REGISTERS(1), .PRE_DECODE(1'b0), .BASE_ADDRESS(8'h00), .BYTE_SIZE(256),
        .ERROR_STATUS(1'b0), .DEFAULT_READ_DATA(B_DEFAULT), .INSERT_SLICER(1'b1),
        .TIMEOUT_CYCLES(0)
    ) dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .bus_valid(b_bus_valid), .bus_access(b_bus_access), .bus_address(b_bus_address),
        .bus_write_data(b_bus_write_data), .bus_strobe(b_bus_strobe),
        .bus_ready(b_bus_ready), .bus_status(b_bus_status), .bus_read_data(b_bus_read_data),
        .register_valid(b_register_valid), .register_access(b_register_access),
        .register_address(b_register_address), .register_write_data(b_register_write_data),
        .register_strobe(b_register_strobe), .register_active(b_reg_active),
        .register_ready(b_reg_ready), .register_status(b_reg_status),
        .register_read_data(b_reg_read_data), .o_busy(b_busy), .o_timeout(b_timeout)
    );

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] strobe);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (strobe[i]) mask[i*8 +: 8] = 8'hFF;
        end
        return mask;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One transaction on A; sel 0 = no register active, else register sel-1 answers
    // after 'delay' cycles counted from the issue cycle.
    task automatic apply_stimulus_a(input logic [7:0] addr, input int sel, input int delay,
                                    input logic [1:0] sel_status, input logic [31:0] sel_data);
        rggen_access acc;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        in_window;
        logic [1:0]  mask;
        int          exp_latency;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        logic        exp_timeout;
        int          cycles;
        acc   = rggen_access'(2'($urandom_range(1, 3)));
        wdata = $urandom;
        strb  = 4'($urandom);
        in_window = (addr >= 8'h40) && (addr <= 8'h4F);
        mask = 2'b00;
        if (sel > 0) mask[sel-1] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            a_reg_status[r]    = 2'($urandom);
            a_reg_read_data[r] = $urandom;
        end
        if (sel > 0) begin
            a_reg_status[sel-1]    = sel_status;
            a_reg_read_data[sel-1] = sel_data;
        end
        if (!in_window || sel == 0) begin
            exp_latency = 1; exp_status = RGGEN_SLAVE_ERROR; exp_data = A_DEFAULT; exp_timeout = 1'b0;
        end else if (delay <= A_TIMEOUT) begin
            exp_latency = 1 + delay; exp_status = sel_status; exp_data = sel_data; exp_timeout = 1'b0;
        end else begin
            exp_latency = 1 + A_TIMEOUT; exp_status = RGGEN_SLAVE_ERROR; exp_data = A_DEFAULT;
            exp_timeout = 1'b1;
        end

        a_bus_valid = 1'b1; a_bus_access = acc; a_bus_address = addr;
        a_bus_write_data = wdata; a_bus_strobe = strb;
        a_reg_active = mask;
        a_reg_ready  = (delay == 0) ? mask : 2'b00;
        #1;
        check_output("a_issue_valid", a_register_valid, in_window);
        if (in_window) begin
            check_output("a_issue_access", a_register_access, acc);
            check_output("a_issue_address", a_register_address, 8'(addr - 8'h40));
            check_output("a_issue_wdata", a_register_write_data, wdata);
            check_output("a_issue_strobe", a_register_strobe, byte_mask(strb));
        end
        cycles = 0;
        while (!a_bus_ready && cycles < 16) begin
            tick();
            cycles++;
            if (!a_bus_ready) begin
                check_output("a_valid_single", a_register_valid, 1'b0);
                a_reg_ready = (cycles == delay) ? mask : 2'b00;
            end
        end
        check_output("a_latency", cycles, exp_latency);
        check_output("a_status", a_bus_status, exp_status);
        check_output("a_rdata", a_bus_read_data, exp_data);
        check_output("a_timeout", a_timeout, exp_timeout);

        // A late ready while idle must not produce another response.
        a_bus_valid = 1'b0;
        a_reg_ready = mask;
        tick();
        check_output("a_ready_pulse", a_bus_ready, 1'b0);
        check_output("a_timeout_pulse", a_timeout, 1'b0);
        check_output("a_idle_busy", a_busy, 1'b0);
        check_output("a_status_hold", a_bus_status, exp_status);
        a_reg_ready  = 2'b00;
        a_reg_active = 2'b00;
    endtask

    task automatic apply_stimulus_b(input logic [7:0] addr, input rggen_access acc,
                                    input logic [31:0] wdata, input logic [3:0] strb,
                                    input logic active, input int delay);
        int          exp_latency;
        logic [1:0]  exp_status;
        logic [31:0] exp_data;
        int          cycles;
        b_reg_status[0]    = 2'($urandom);
        b_reg_read_data[0] = $urandom;
        exp_latency = active ? 2 + delay : 2;
        exp_status  = active ? b_reg_status[0] : RGGEN_OKAY;
        exp_data    = active ? b_reg_read_data[0] : B_DEFAULT;

        b_bus_valid = 1'b1; b_bus_access = acc; b_bus_address = addr;
        b_bus_write_data = wdata; b_bus_strobe = strb;
        b_reg_active = active; b_reg_ready = 1'b0;
        #1;
        check_output("b_slice_cycle_valid", b_register_valid, 1'b0);
        tick();
        cycles = 1;
        // Disturb the bus to show the issued request comes from the latched copy.
        b_bus_address = ~addr; b_bus_write_data = ~wdata; b_bus_strobe = ~strb;
        b_reg_ready = active && (delay == 0);
        #1;
        check_output("b_issue_valid", b_register_valid, 1'b1);
        check_output("b_issue_access", b_register_access, acc);
        check_output("b_issue_address", b_register_address, addr);
        check_output("b_issue_wdata", b_register_write_data, wdata);
        check_output("b_issue_strobe", b_register_strobe, byte_mask(strb));
        while (!b_bus_ready && cycles < 16) begin
            tick();
            cycles++;
            if (!b_bus_ready) b_reg_ready = active && (cycles - 1 == delay);
        end
        check_output("b_latency", cycles, exp_latency);
        check_output("b_status", b_bus_status, exp_status);
        check_output("b_rdata", b_bus_read_data, exp_data);
        check_output("b_timeout", b_timeout, 1'b0);
        b_bus_valid = 1'b0; b_reg_ready = 1'b0; b_reg_active = 1'b0;
        tick();
        check_output("b_idle_busy", b_busy, 1'b0);
        check_output("b_ready_pulse", b_bus_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        i_rst_n = 1'b0;
        a_bus_valid = 1'b0; a_bus_access = RGGEN_READ; a_bus_address = '0;
        a_bus_write_data = '0; a_bus_strobe = '0;
        a_reg_active = '0; a_reg_ready = '0; a_reg_status = '0; a_reg_read_data = '0;
        b_bus_valid = 1'b0; b_bus_access = RGGEN_READ; b_bus_address = '0;
        b_bus_write_data = '0; b_bus_strobe = '0;
        b_reg_active = '0; b_reg_ready = '0; b_reg_status = '0; b_reg_read_data = '0;
        #1;
        check_output("rst_a_ready", a_bus_ready, 1'b0);
        check_output("rst_a_status", a_bus_status, RGGEN_OKAY);
        check_output("rst_a_rdata", a_bus_read_data, 32'h0);
        check_output("rst_a_busy", a_busy, 1'b0);
        check_output("rst_a_timeout", a_timeout, 1'b0);
        check_output("rst_a_reg_valid", a_register_valid, 1'b0);
        check_output("rst_b_ready", b_bus_ready, 1'b0);
        check_output("rst_b_busy", b_busy, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        apply_stimulus_a(8'h44, 2, 0, RGGEN_OKAY, 32'hDEAD_BEEF);
        apply_stimulus_a(8'h80, 1, 0, RGGEN_OKAY, 32'h1111_2222);
        apply_stimulus_a(8'h48, 1, 9, RGGEN_OKAY, 32'h3333_4444);
        apply_stimulus_a(8'h4C, 2, A_TIMEOUT, RGGEN_EXOKAY, 32'h7777_8888);
        apply_stimulus_a(8'h3F, 1, 0, RGGEN_OKAY, 32'h9999_0000);
        apply_stimulus_a(8'h4F, 1, 1, RGGEN_OKAY, 32'hABCD_0123);

        // Reset pulsed while the adapter is waiting on a silent register.
        a_bus_valid = 1'b1; a_bus_address = 8'h41; a_bus_access = RGGEN_READ;
        a_reg_active = 2'b01; a_reg_ready = 2'b00;
        repeat (3) tick();
        check_output("mid_busy", a_busy, 1'b1);
        a_bus_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_output("mid_rst_ready", a_bus_ready, 1'b0);
        check_output("mid_rst_status", a_bus_status, RGGEN_OKAY);
        check_output("mid_rst_rdata", a_bus_read_data, 32'h0);
        check_output("mid_rst_busy", a_busy, 1'b0);
        check_output("mid_rst_timeout", a_timeout, 1'b0);
        check_output("mid_rst_reg_valid", a_register_valid, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        a_reg_active = 2'b00;
        tick();
        apply_stimulus_a(8'h43, 1, 2, RGGEN_OKAY, 32'h0BAD_F00D);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] addr;
            int         sel;
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h40 + 8'($urandom_range(0, 15));
            sel  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 2));
            apply_stimulus_a(addr, sel, int'($urandom_range(0, 6)), 2'($urandom), $urandom);
        end

        apply_stimulus_b(8'h04, RGGEN_WRITE, 32'h1234_5678, 4'b0011, 1'b1, 0);
        apply_stimulus_b(8'hF0, RGGEN_READ, 32'h0, 4'b0000, 1'b0, 0);
        for (int n = 0; n < 10; n++) begin
            apply_stimulus_b(8'($urandom), rggen_access'(2'($urandom_range(1, 3))), $urandom,
                             4'($urandom), $urandom_range(0, 5) != 0, int'($urandom_range(0, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
